xgmii_tx_mac: RTL and testbench

Transmit MAC for the 10G Ethernet datapath. It accepts frame bytes (destination MAC through end of payload) on an AXI-Stream slave and emits complete frames on a 32-bit XGMII-style transmit bus. Each frame carries start/preamble/SFD, zero padding to the minimum length, an appended CRC-32 FCS, a terminate character, and an inter-frame gap. It sits between the user/packet logic and the PCS (64b/66b encoder/gearbox), which back-pressures it through `i_xgmii_pause`.

---
 rtl/xgmii_tx_mac.sv | 199 +++++++++++++++++++
 tb/tb_xgmii_tx_mac.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_tx_mac.sv
// Transmit MAC: AXI-Stream frame bytes in, 32-bit XGMII words out with
// preamble/SFD, zero pad to 60 bytes, CRC-32 FCS, terminate and inter-frame gap.
module xgmii_tx_mac #(
   parameter int XGMII_DATA_WIDTH = 32,
   parameter int XGMII_CTRL_WIDTH = 4
) (
   input  logic                        i_clk,
   input  logic                        i_reset_n,
   output logic [XGMII_DATA_WIDTH-1:0] o_xgmii_txd,
   output logic [XGMII_CTRL_WIDTH-1:0] o_xgmii_ctrl,
   output logic                        o_xgmii_valid,
   input  logic                        i_xgmii_pause,
   input  logic [XGMII_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [XGMII_CTRL_WIDTH-1:0] s_axis_tkeep,
   input  logic                        s_axis_tvalid,
   input  logic                        s_axis_tlast,
   output logic                        s_axis_trdy
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_PREAMBLE, ST_PAYLOAD, ST_PAD, ST_FCS, ST_TERM, ST_IFG
   } state_t;

   localparam logic [31:0] IDLE_WORD = 32'h07070707;
   localparam logic [31:0] ERR_WORD  = 32'hFEFEFEFE;
   localparam logic [31:0] TERM_WORD = 32'h070707FD;

   state_t      state;
   logic        sfd_next;
   logic [31:0] crc;
   logic [6:0]  cnt;
   logic [1:0]  fcs_k;
   logic        ifg_cnt;
   logic        drop;

   logic [2:0]  nb;
   logic [31:0] data_m;
   logic [31:0] crc_last, crc_full, crc_zero;
   logic [31:0] fcs_last, fcs_cur;
   logic [31:0] tail_word, fin_word;
   logic [3:0]  fin_ctrl;
   logic [6:0]  cnt_inc;
   logic        short_frame;

   function automatic logic [31:0] crc_bytes(input logic [31:0] c, input logic [31:0] d,
                                             input logic [2:0] n);
      logic [31:0] r;
      r = c;
      for (int unsigned i = 0; i < 4; i++) begin
         if (i < 32'(n)) begin
            r = r ^ {24'h0, d[8*i +: 8]};
            for (int unsigned b = 0; b < 8; b++)
               r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
         end
      end
      return r;
   endfunction

   always_comb begin
      nb     = 3'd1;
      data_m = '0;
      if (s_axis_tkeep[3])      nb = 3'd4;
      else if (s_axis_tkeep[2]) nb = 3'd3;
      else if (s_axis_tkeep[1]) nb = 3'd2;
      for (int unsigned i = 0; i < 4; i++)
         data_m[8*i +: 8] = s_axis_tkeep[i] ? s_axis_tdata[8*i +: 8] : 8'h00;
   end

   assign crc_last    = crc_bytes(crc, data_m, nb);
   assign crc_full    = crc_bytes(crc, data_m, 3'd4);
   assign crc_zero    = crc_bytes(crc, '0, 3'd4);
   assign cnt_inc     = (cnt >= 7'd64) ? cnt : cnt + 7'd4;
   assign short_frame = ({1'b0, cnt} + {5'b0, nb}) < 8'd60;

   // tail_word: last data bytes followed by the leading FCS bytes in the same word.
   // fin_word: FCS bytes that spilled into the next word, then FD and idles.
   always_comb begin
      fcs_last  = ~crc_last;
      fcs_cur   = ~crc;
      tail_word = data_m;
      fin_word  = IDLE_WORD;
      fin_ctrl  = '1;
      for (int unsigned i = 0; i < 4; i++) begin
         if (i >= 32'(nb))
            tail_word[8*i +: 8] = fcs_last[8*(i - 32'(nb)) +: 8];
         if (i < 32'(fcs_k)) begin
            fin_word[8*i +: 8] = fcs_cur[8*(4 - 32'(fcs_k) + i) +: 8];
            fin_ctrl[i]        = 1'b0;
         end else if (i == 32'(fcs_k)) begin
            fin_word[8*i +: 8] = 8'hFD;
         end
      end
   end

   always_comb s_axis_trdy = !i_xgmii_pause && ((state == ST_PAYLOAD) || drop);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= ST_IDLE;
         sfd_next      <= 1'b0;
         crc           <= '1;
         cnt           <= '0;
         fcs_k         <= '0;
         ifg_cnt       <= 1'b0;
         drop          <= 1'b0;
         o_xgmii_txd   <= IDLE_WORD;
         o_xgmii_ctrl  <= '1;
         o_xgmii_valid <= 1'b0;
      end else if (i_xgmii_pause) begin
         o_xgmii_valid <= 1'b0;
      end else begin
         o_xgmii_valid <= 1'b1;
         if (drop && s_axis_tvalid && s_axis_tlast)
            drop <= 1'b0;
         case (state)
            ST_IDLE: begin
               o_xgmii_txd  <= IDLE_WORD;
               o_xgmii_ctrl <= '1;
               if (s_axis_tvalid && !drop) begin
                  state    <= ST_PREAMBLE;
                  sfd_next <= 1'b0;
                  crc      <= '1;
                  cnt      <= '0;
               end
            end
            ST_PREAMBLE: begin
               if (!sfd_next) begin
                  o_xgmii_txd  <= 32'h555555FB;
                  o_xgmii_ctrl <= 4'h1;
                  sfd_next     <= 1'b1;
               end else begin
                  o_xgmii_txd  <= 32'hD5555555;
                  o_xgmii_ctrl <= 4'h0;
                  state        <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               o_xgmii_ctrl <= 4'h0;
               if (!s_axis_tvalid) begin
                  o_xgmii_txd  <= ERR_WORD;
                  o_xgmii_ctrl <= '1;
                  drop         <= 1'b1;
                  state        <= ST_TERM;
               end else if (!s_axis_tlast || short_frame) begin
                  o_xgmii_txd <= data_m;
                  crc         <= crc_full;
                  cnt         <= cnt_inc;
                  fcs_k       <= '0;
                  if (s_axis_tlast)
                     state <= (cnt_inc >= 7'd60) ? ST_FCS : ST_PAD;
               end else begin
                  o_xgmii_txd <= tail_word;
                  crc         <= crc_last;
                  fcs_k       <= nb[1:0];
                  state       <= ST_FCS;
               end
            end
            ST_PAD: begin
               o_xgmii_txd  <= '0;
               o_xgmii_ctrl <= 4'h0;
               crc          <= crc_zero;
               cnt          <= cnt_inc;
               if (cnt_inc >= 7'd60) begin
                  fcs_k <= '0;
                  state <= ST_FCS;
               end
            end
            ST_FCS: begin
               if (fcs_k == 2'd0) begin
                  o_xgmii_txd  <= fcs_cur;
                  o_xgmii_ctrl <= 4'h0;
                  state        <= ST_TERM;
               end else begin
                  o_xgmii_txd  <= fin_word;
                  o_xgmii_ctrl <= fin_ctrl;
                  ifg_cnt      <= 1'b0;
                  state        <= ST_IFG;
               end
            end
            ST_TERM: begin
               o_xgmii_txd  <= TERM_WORD;
               o_xgmii_ctrl <= '1;
               ifg_cnt      <= 1'b0;
               state        <= ST_IFG;
            end
            ST_IFG: begin
               // Two idle words here plus the idle word emitted in IDLE give >= 12 idle bytes.
               o_xgmii_txd  <= IDLE_WORD;
               o_xgmii_ctrl <= '1;
               ifg_cnt      <= 1'b1;
               if (ifg_cnt)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xgmii_tx_mac.sv
// Scoreboard bench for xgmii_tx_mac: directed frames, pause, back-to-back, underrun, reset.
module tb_xgmii_tx_mac;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_xgmii_pause = 1'b0;
   logic [31:0] s_axis_tdata;
   logic [3:0]  s_axis_tkeep;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic        s_axis_trdy;
   logic [31:0] o_xgmii_txd;
   logic [3:0]  o_xgmii_ctrl;
   logic        o_xgmii_valid;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  c;
      bit          start;
      bit          term;
      int          idles;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  frm [0:255];
   logic [7:0]  sb  [0:255];
   logic        sc  [0:255];
   bit          pause_en = 0;
   bit          mon_en = 1;
   bit          aborted = 0;
   bit          live;
   logic        pause_q;
   bit          have_prev = 0;
   int          gap_bytes = 0;
   int          idle_words = 0;
   int          word_idx = 0;

   always #5 i_clk = ~i_clk;

   xgmii_tx_mac #(.XGMII_DATA_WIDTH(32), .XGMII_CTRL_WIDTH(4)) dut (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .o_xgmii_txd   (o_xgmii_txd),
      .o_xgmii_ctrl  (o_xgmii_ctrl),
      .o_xgmii_valid (o_xgmii_valid),
      .i_xgmii_pause (i_xgmii_pause),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_trdy   (s_axis_trdy)
   );

   always @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         live    <= 1'b0;
         pause_q <= 1'b0;
      end else begin
         live    <= 1'b1;
         pause_q <= i_xgmii_pause;
      end
   end

   initial begin
      forever begin
         @(posedge i_clk);
         #2;
         i_xgmii_pause = pause_en ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
   end

   // Monitor: pops the expected word whenever the DUT presents a valid word.
   always @(negedge i_clk) begin
      exp_t e;
      if (live && mon_en) begin
         checks++;
         if (o_xgmii_valid !== !pause_q) begin
            errors++;
            $display("FAIL valid_vs_pause: valid=%0b required=%0b at %0t", o_xgmii_valid, !pause_q, $time);
         end
         if (o_xgmii_valid === 1'b1) begin
            if ((exp_q.size() == 0 || exp_q[0].start) && o_xgmii_txd == 32'h07070707 && o_xgmii_ctrl == 4'hF) begin
               idle_words++;
            end else if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: txd=%08h ctrl=%h required idle at %0t", o_xgmii_txd, o_xgmii_ctrl, $time);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (o_xgmii_txd !== e.d || o_xgmii_ctrl !== e.c) begin
                  errors++;
                  $display("FAIL word_%0d: txd=%08h ctrl=%h required txd=%08h ctrl=%h", word_idx, o_xgmii_txd, o_xgmii_ctrl, e.d, e.c);
               end
               if (e.start && have_prev) begin
                  checks++;
                  if (gap_bytes + 4 * idle_words < 12) begin
                     errors++;
                     $display("FAIL ifg_gap: idle bytes=%0d required>=12", gap_bytes + 4 * idle_words);
                  end
               end
               if (e.term) begin
                  have_prev  = 1;
                  gap_bytes  = e.idles;
                  idle_words = 0;
               end
               word_idx++;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %08h required %08h", name, act, req);
      end
   endtask

   function automatic logic [31:0] fcs_of(input int n);
      logic [31:0] c;
      logic        fb;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ sb[i][b];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
         end
      return ~c;
   endfunction

   task automatic fill(input int len, input int base, input int step);
      for (int i = 0; i < len; i++)
         frm[i] = 8'((base + i * step) & 255);
   endtask

   task automatic push_word(input logic [31:0] d, input logic [3:0] c, input bit st, input bit tm, input int idl);
      exp_t e;
      e.d = d; e.c = c; e.start = st; e.term = tm; e.idles = idl;
      exp_q.push_back(e);
   endtask

   // Expected wire image: START, SFD, data, zero pad to 60, FCS LSB first, FD, idle fill.
   task automatic push_expected(input int len, input int ur);
      int n, pl, fdpos, nw;
      logic [31:0] f;
      push_word(32'h555555FB, 4'h1, 1, 0, 0);
      push_word(32'hD5555555, 4'h0, 0, 0, 0);
      if (ur >= 0) begin
         for (int b = 0; b < ur; b++)
            push_word({frm[4*b+3], frm[4*b+2], frm[4*b+1], frm[4*b]}, 4'h0, 0, 0, 0);
         push_word(32'hFEFEFEFE, 4'hF, 0, 0, 0);
         push_word(32'h070707FD, 4'hF, 0, 1, 3);
         return;
      end
      pl = (len < 60) ? 60 : len;
      for (int i = 0; i < pl; i++) begin
         sb[i] = (i < len) ? frm[i] : 8'h00;
         sc[i] = 1'b0;
      end
      f = fcs_of(pl);
      n = pl;
      for (int k = 0; k < 4; k++) begin
         sb[n] = f[8*k +: 8];
         sc[n] = 1'b0;
         n++;
      end
      sb[n] = 8'hFD; sc[n] = 1'b1; fdpos = n; n++;
      while (n % 4 != 0) begin
         sb[n] = 8'h07; sc[n] = 1'b1; n++;
      end
      nw = n / 4;
      for (int w = 0; w < nw; w++)
         push_word({sb[4*w+3], sb[4*w+2], sb[4*w+1], sb[4*w]},
                   {sc[4*w+3], sc[4*w+2], sc[4*w+1], sc[4*w]},
                   0, (w == nw - 1), 3 - (fdpos % 4));
   endtask

   task automatic wait_accept();
      int n;
      n = 0;
      if (aborted) return;
      forever begin
         @(negedge i_clk);
         if (s_axis_trdy) break;
         n++;
         if (n > 500) begin
            checks++;
            errors++;
            aborted = 1;
            $display("FAIL accept_timeout: trdy=0 for %0d cycles required 1", n);
            return;
         end
      end
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [7:0] get_byte(input int idx, input int len);
      return (idx < len) ? frm[idx] : 8'hEE;
   endfunction

   task automatic send_frame(input int len, input int ur, input bit keep_valid);
      int nbeats, rem;
      nbeats = (len + 3) / 4;
      for (int b = 0; b < nbeats; b++) begin
         if (b == ur) begin
            s_axis_tvalid = 1'b0;
            wait_accept();
         end
         s_axis_tdata  = {get_byte(4*b+3, len), get_byte(4*b+2, len), get_byte(4*b+1, len), get_byte(4*b, len)};
         rem           = len - 4 * b;
         s_axis_tkeep  = (rem >= 4) ? 4'hF : (rem == 3) ? 4'h7 : (rem == 2) ? 4'h3 : 4'h1;
         s_axis_tlast  = (b == nbeats - 1);
         s_axis_tvalid = 1'b1;
         wait_accept();
      end
      if (!keep_valid) begin
         s_axis_tvalid = 1'b0;
         s_axis_tlast  = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 3000) begin
         @(posedge i_clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d words pending required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_reset_n     = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_txd",   o_xgmii_txd, 32'h07070707);
      chk("rst_ctrl",  32'(o_xgmii_ctrl), 32'hF);
      chk("rst_valid", 32'(o_xgmii_valid), 32'h0);
      chk("rst_trdy",  32'(s_axis_trdy), 32'h0);
      #3 i_reset_n = 1'b1;
      repeat (4) @(posedge i_clk);
      #1;

      fill(64, 8'h00, 1);  push_expected(64, -1);  send_frame(64, -1, 0);
      fill(14, 8'hA0, 1);  push_expected(14, -1);  send_frame(14, -1, 0);
      fill(61, 8'h11, 3);  push_expected(61, -1);  send_frame(61, -1, 0);
      wait_drain();

      fill(100, 8'h5A, 5); push_expected(100, -1); send_frame(100, -1, 0);
      wait_drain();
      pause_en = 1;
      push_expected(100, -1); send_frame(100, -1, 0);
      wait_drain();
      pause_en = 0;
      repeat (2) @(posedge i_clk);
      #1;

      fill(60, 8'h20, 1);  push_expected(60, -1);  send_frame(60, -1, 1);
      fill(63, 8'hC0, 7);  push_expected(63, -1);  send_frame(63, -1, 1);
      fill(62, 8'h03, 9);  push_expected(62, -1);  send_frame(62, -1, 0);
      wait_drain();

      fill(40, 8'h80, 1);  push_expected(40, 5);   send_frame(40, 5, 0);
      fill(64, 8'h33, 1);  push_expected(64, -1);  send_frame(64, -1, 0);
      wait_drain();

      mon_en        = 0;
      s_axis_tdata  = 32'hDEADBEEF;
      s_axis_tkeep  = 4'hF;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      repeat (6) @(posedge i_clk);
      #1;
      i_reset_n = 1'b0;
      #1;
      chk("abort_txd",   o_xgmii_txd, 32'h07070707);
      chk("abort_ctrl",  32'(o_xgmii_ctrl), 32'hF);
      chk("abort_valid", 32'(o_xgmii_valid), 32'h0);
      chk("abort_trdy",  32'(s_axis_trdy), 32'h0);
      s_axis_tvalid = 1'b0;
      @(posedge i_clk);
      #3;
      have_prev  = 0;
      idle_words = 0;
      exp_q.delete();
      i_reset_n = 1'b1;
      mon_en    = 1;
      repeat (6) @(posedge i_clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
